// File: rtl/uart_byte_tx_pkg.sv
// Shared definitions for the byte-wide UART transmitter: FSM state encoding
// and the default bit period.
package uart_byte_tx_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 434;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO; pointers carry an extra MSB so full and empty
// are distinguishable when the address bits match.
module byte_fifo #(
    parameter int unsigned AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int unsigned Depth = 2 ** AW;

    logic [7:0]  mem [Depth];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames run back to back
// while bytes are queued.
module uart_byte_tx
    import uart_byte_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       write,
    input  logic [7:0] data,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam logic [15:0] TimerLast = 16'(CLK_DIV - 1);

    tx_state_t   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        overflow_q, overflow_d;

    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;

    byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (write),
        .din   (data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign tx       = tx_q;
    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle) || !fifo_empty;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        // full is sampled before any pop on this edge, so the byte is lost
        overflow_d = overflow_q || (write && fifo_full);

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    timer_d  = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (timer_q == TimerLast) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StData: begin
                if (timer_q == TimerLast) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StStop: begin
                if (timer_q == TimerLast) begin
                    timer_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the state being entered so tx is registered yet on time.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Randomized bench for uart_byte_tx, checked cycle by cycle against a
// frame-timeline model of the serial line and byte queue.
module tb_uart_byte_tx;

    localparam int Div   = 4;
    localparam int Aw    = 2;
    localparam int Depth = 1 << Aw;
    localparam int Frame = 10 * Div;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx, full, busy, overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference: queued bytes plus position inside the current frame.
    logic [7:0] q[$];
    bit         act;
    logic [7:0] cur;
    int         cnt;
    bit         ovf;

    uart_byte_tx #(
        .CLK_DIV (Div),
        .FIFO_AW (Aw)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .data     (data),
        .tx       (tx),
        .full     (full),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        act = 1'b0;
        cnt = 0;
        ovf = 1'b0;
    endtask

    task automatic model_edge(input bit w, input logic [7:0] d);
        bit full_pre;
        bit can_pop;
        full_pre = (q.size() == Depth);
        can_pop  = (q.size() > 0);
        if (act) begin
            if (cnt == Frame - 1) begin
                if (can_pop) begin
                    cur = q.pop_front();
                    cnt = 0;
                end else begin
                    act = 1'b0;
                end
            end else begin
                cnt++;
            end
        end else if (can_pop) begin
            cur = q.pop_front();
            act = 1'b1;
            cnt = 0;
        end
        if (w) begin
            if (full_pre) ovf = 1'b1;
            else q.push_back(d);
        end
    endtask

    function automatic logic exp_tx();
        if (!act)              return 1'b1;
        if (cnt < Div)         return 1'b0;
        if (cnt < 9 * Div)     return cur[(cnt - Div) / Div];
        return 1'b1;
    endfunction

    task automatic compare_all();
        check("tx", tx, exp_tx());
        check("busy", busy, act || (q.size() > 0));
        check("full", full, q.size() == Depth);
        check("overflow", overflow, ovf);
    endtask

    task automatic step(input bit w, input logic [7:0] d);
        write = w;
        data  = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(w, d);
        @(negedge clk);
        write = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        step(1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        cur = 8'h00;
        @(negedge clk);
        do_reset();

        // Single byte: one full frame then idle.
        step(1'b1, 8'hA5);
        idle(Frame + 5);
        check("a5_idle_busy", busy, 1'b0);

        // Four bytes back to back: contiguous frames, full never asserts.
        step(1'b1, 8'h31);
        step(1'b1, 8'h32);
        step(1'b1, 8'h33);
        step(1'b1, 8'h34);
        idle(4 * Frame + 5);

        // Six writes in a row: the sixth finds the FIFO full and is dropped.
        for (int i = 0; i < 6; i++) step(1'b1, 8'h50 + 8'(i));
        check("six_overflow", overflow, 1'b1);
        idle(5 * Frame + 5);
        check("six_overflow_sticky", overflow, 1'b1);

        // Write while full on the same edge as the end-of-stop pop.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i));
        check("pre_full", full, 1'b1);
        guard = 0;
        while (!(act && cnt == Frame - 1) && guard < 2 * Frame) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check("stop_end_reached", guard < 2 * Frame, 1'b1);
        step(1'b1, 8'hEE);
        check("stop_pop_overflow", overflow, 1'b1);
        check("stop_pop_full", full, 1'b0);
        idle(5 * Frame + 5);

        // Reset during data bit 3 of 8'h0F with two bytes queued.
        do_reset();
        step(1'b1, 8'h0F);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        guard = 0;
        while (!(act && cnt == 4 * Div + 1) && guard < 2 * Frame) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check("bit3_reached", guard < 2 * Frame, 1'b1);
        check("bit3_queued", q.size(), 2);
        do_reset();
        idle(3 * Frame);
        check("post_rst_tx", tx, 1'b1);

        // Random traffic, then drain.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 2), 8'($urandom));
        end
        idle(5 * Frame + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLK_DIV, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_AW, default 2, FIFO address width; depth = 2**FIFO_AW (4 entries).
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port write  input  1  byte-valid strobe from the upstream byte splitter, one byte per high cycle.
REQ-006 Port data  input  8  byte to transmit, sampled on a clk edge where write=1.
REQ-007 Port tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-008 Port full  output  1  high while the FIFO holds 2**FIFO_AW bytes.
REQ-009 Port busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-010 Port overflow  output  1  sticky flag, set when a byte is dropped.

Function
REQ-011 A write edge with full=0 SHALL push data into the FIFO; a write edge with full=1 SHALL drop the byte, leave the FIFO unchanged and set overflow.
REQ-012 A write and an FSM pop on the same edge SHALL both take effect; full is evaluated before the pop, so a write while full is dropped even if a pop occurs that edge.
REQ-013 FSM states: IDLE, START, DATA, STOP; a 16-bit bit-timer counts 0..CLK_DIV-1 and a 3-bit bit index counts 0..7.
REQ-014 IDLE: tx=1; on an edge where the FIFO is non-empty, pop the head byte into the shift register, clear the timer, go to START.
REQ-015 START: tx=0 for exactly CLK_DIV cycles, then go to DATA with bit index 0.
REQ-016 DATA: tx=shift[0] for CLK_DIV cycles per bit; shift right after each bit; after bit 7 go to STOP.
REQ-017 STOP: tx=1 for CLK_DIV cycles; at its end, pop and go directly to START if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-018 Latency: write sampled at edge E into an empty FIFO with FSM in IDLE -> pop at edge E+1, tx low from E+1 through E+1+CLK_DIV.
REQ-019 Frame length SHALL be exactly 10*CLK_DIV cycles; back-to-back frames SHALL be 10*CLK_DIV apart.
REQ-020 tx SHALL be driven from a register (glitch-free).
REQ-021 FIFO pointers SHALL wrap modulo 2**FIFO_AW using an extra MSB to distinguish full from empty.
REQ-022 busy SHALL be the OR of (state != IDLE) and FIFO non-empty.

Reset
REQ-023 rst SHALL asynchronously force tx=1, full=0, busy=0, overflow=0, state=IDLE, timer=0, bit index=0, FIFO pointers=0.
REQ-024 rst mid-frame SHALL abort the frame immediately, discard all queued bytes, and drive tx high; no partial frame resumes after release.
REQ-025 overflow SHALL clear only on rst.

Structure
REQ-026 The shared package SHALL hold the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default CLK_DIV constant.
REQ-027 The FIFO SHALL be a separate sub-module byte_fifo (parameter AW; ports clk, rst, push, din, pop, dout, empty, full); the serializer FSM lives in uart_byte_tx.

Verification (CLK_DIV=4, FIFO_AW=2)
REQ-028 Reset, then a single write of 8'hA5 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy falls after the stop bit; 40 cycles total.
REQ-029 Four consecutive writes 8'h31,8'h32,8'h33,8'h34 (as one 32-bit word split by the upstream stage) -> four contiguous frames, 160 cycles, no idle gap; full never asserts, since the first byte is popped before the fourth arrives.
REQ-030 Six consecutive writes while the FSM is held mid-frame -> full rises after the FIFO reaches 4 entries, the excess byte is dropped, overflow=1 and stays 1, and the received bytes match those accepted in order.
REQ-031 Write while full on the same edge as a STOP-end pop -> byte dropped, overflow=1, FIFO count decreases by one.
REQ-032 Assert rst during DATA bit 3 of 8'h0F with 2 bytes queued -> tx=1 within the same cycle, busy=0, full=0; after release no further frame appears until a new write.
